mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/pipeline_defines.sv | 44 ++++
 rtl/mem_load_align.sv | 34 +++
 rtl/mem_stage.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pipeline_defines.sv
// rtl/pipeline_defines.sv - shared pipeline buffer types and ALU op codes
package pipeline_defines;

    typedef enum logic [3:0] {
        ALU_NOP, ALU_ADD, ALU_OR,
        LD_B, LD_BU, LD_H, LD_HU, LD_W, LL,
        ST_B, ST_H, ST_W, SC
    } aluop_t;

    typedef struct packed {
        aluop_t      aluop;
        logic [31:0] mem_addr;
        logic [31:0] reg2;
        logic [4:0]  waddr;
        logic        wreg;
        logic [31:0] wdata;
        logic        excp;
        logic [31:0] instr_info;
    } ex_mem_struct;

    typedef struct packed {
        logic [4:0]  waddr;
        logic        wreg;
        logic [31:0] wdata;
        logic        excp;
        logic [31:0] instr_info;
    } mem_wb_struct;

    typedef struct packed {
        logic        is_load_data;
        logic        wreg;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } mem_data_forward_t;

    function automatic logic is_load_op(aluop_t op);
        return op inside {LD_B, LD_BU, LD_H, LD_HU, LD_W, LL};
    endfunction

    function automatic logic is_store_op(aluop_t op);
        return op inside {ST_B, ST_H, ST_W, SC};
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - selects the addressed lane of load data and extends it
module mem_load_align
    import pipeline_defines::*;
(
    input  aluop_t      aluop,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (aluop)
            LD_B:    data = {{24{byte_lane[7]}}, byte_lane};
            LD_BU:   data = {24'd0, byte_lane};
            LD_H:    data = {{16{half_lane[15]}}, half_lane};
            LD_HU:   data = {16'd0, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: data-bus handshake, load/store shaping, LL/SC link
module mem_stage
    import pipeline_defines::*;
(
    input  logic              clk,
    input  logic              rst,
    input  ex_mem_struct      ex_i,
    output logic              data_req_o,
    output logic              data_we_o,
    output logic [3:0]        data_be_o,
    output logic [31:0]       data_addr_o,
    output logic [31:0]       data_wdata_o,
    input  logic              data_addr_ok_i,
    input  logic              data_data_ok_i,
    input  logic [31:0]       data_rdata_i,
    input  logic              flush,
    input  logic              excp_flush,
    input  logic              ertn_flush,
    input  logic              stall,
    output logic              stallreq_o,
    output logic              llbit_o,
    output mem_wb_struct      mem_o_buffer,
    output mem_data_forward_t mem_data_forward_o
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;

    state_t       state;
    logic         llbit;
    logic         flush_seen;
    logic [31:0]  hold;
    logic [31:0]  load_data;
    logic         any_flush;
    logic         sc_fail;
    logic         is_mem;
    logic         issue;
    mem_wb_struct result;

    assign any_flush = flush | excp_flush | ertn_flush;
    assign sc_fail   = (ex_i.aluop == SC) && !ex_i.excp && !llbit;
    assign is_mem    = (is_load_op(ex_i.aluop) || is_store_op(ex_i.aluop)) && !ex_i.excp && !sc_fail;
    assign issue     = (state == S_IDLE) && is_mem && !any_flush;

    assign data_req_o  = !rst && (issue || state == S_REQ);
    assign data_we_o   = is_store_op(ex_i.aluop);
    assign data_addr_o = ex_i.mem_addr;
    assign stallreq_o  = !rst && ((state inside {S_REQ, S_WAIT, S_DRAIN}) || (state == S_IDLE && is_mem));
    assign llbit_o     = llbit;

    always_comb begin
        data_be_o    = 4'b1111;
        data_wdata_o = ex_i.reg2;
        case (ex_i.aluop)
            LD_B, LD_BU, ST_B: begin
                data_be_o    = 4'b0001 << ex_i.mem_addr[1:0];
                data_wdata_o = {4{ex_i.reg2[7:0]}};
            end
            LD_H, LD_HU, ST_H: begin
                data_be_o    = 4'b0011 << {ex_i.mem_addr[1], 1'b0};
                data_wdata_o = {2{ex_i.reg2[15:0]}};
            end
            default: ;
        endcase
    end

    mem_load_align u_load_align (
        .aluop (ex_i.aluop),
        .addr  (ex_i.mem_addr[1:0]),
        .rdata (data_rdata_i),
        .data  (load_data)
    );

    // A flush during REQ cannot cancel the bus request, so it is remembered and the reply drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            llbit      <= 1'b0;
            hold       <= 32'd0;
            flush_seen <= 1'b0;
        end else begin
            if (ertn_flush)
                llbit <= 1'b0;
            case (state)
                S_IDLE: if (issue) begin
                    flush_seen <= 1'b0;
                    state      <= data_addr_ok_i ? S_WAIT : S_REQ;
                end
                S_REQ: begin
                    if (any_flush)
                        flush_seen <= 1'b1;
                    if (data_addr_ok_i)
                        state <= (flush_seen || any_flush) ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (any_flush) begin
                        state <= data_data_ok_i ? S_IDLE : S_DRAIN;
                    end else if (data_data_ok_i) begin
                        hold  <= (ex_i.aluop == SC) ? 32'd1 : load_data;
                        state <= S_DONE;
                        if (ex_i.aluop == LL)
                            llbit <= 1'b1;
                        else if (ex_i.aluop == SC)
                            llbit <= 1'b0;
                    end
                end
                S_DONE: if (!stall || any_flush)
                    state <= S_IDLE;
                S_DRAIN: if (data_data_ok_i)
                    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        result.waddr      = ex_i.waddr;
        result.wreg       = ex_i.wreg;
        result.wdata      = ex_i.wdata;
        result.excp       = ex_i.excp;
        result.instr_info = ex_i.instr_info;
        if (state == S_DONE && (is_load_op(ex_i.aluop) || ex_i.aluop == SC))
            result.wdata = hold;
        else if (state == S_IDLE && sc_fail)
            result.wdata = 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst || any_flush)
            mem_o_buffer <= '0;
        else if (!stall)
            mem_o_buffer <= result;
    end

    always_comb begin
        mem_data_forward_o.is_load_data = (state == S_DONE) && is_load_op(ex_i.aluop);
        mem_data_forward_o.wreg         = result.wreg;
        mem_data_forward_o.waddr        = result.waddr;
        mem_data_forward_o.wdata        = result.wdata;
    end

endmodule
